// File: rtl/rv32i_pkg.sv
// Shared RV32I control-transfer definitions: branch funct3 codes, resolver FSM states,
// the default datapath width and the branch-condition decode helper.
package rv32i_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } br_state_t;

  // Signed/unsigned variants share a flag; the comparator mode is picked by BrUn.
  function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = ~eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = ~lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_target_gen.sv
// Control-transfer target adder: pc+imm for branch/JAL, (rs1+imm)&~1 for JALR,
// plus the 4-byte misalignment check on the final target.
module branch_target_gen #(
  parameter int unsigned XLEN = rv32i_pkg::XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic            i_is_jalr,
  output logic [XLEN-1:0] o_target_c,
  output logic            o_misaligned_c
);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;

  always_comb begin
    w_base         = i_is_jalr ? i_rs1 : i_pc;
    w_sum          = w_base + i_imm;
    o_target_c     = w_sum;
    if (i_is_jalr) o_target_c[0] = 1'b0;
    o_misaligned_c = |o_target_c[1:0];
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch/JAL/JALR resolver: redirect handshake to fetch, then an IF/ID drain.
// Define BRANCH_PERF_EN to add the perf_ctrl_cnt / perf_taken_cnt event counters.
module branch_resolve
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN         = rv32i_pkg::XLEN_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  output logic            BrUn,
  input  logic            BrEq,
  input  logic            BrLT,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_o,
`ifdef BRANCH_PERF_EN
  output logic [31:0]     perf_ctrl_cnt,
  output logic [31:0]     perf_taken_cnt,
`endif
  output logic            exc_valid,
  output logic [XLEN-1:0] exc_tval
);

  localparam int unsigned CNT_W = 4;

  br_state_t       r_state;
  logic            r_ex_ready;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_flush;
  logic            r_exc_valid;
  logic [XLEN-1:0] r_exc_tval;
  logic [CNT_W-1:0] r_cnt;

  logic [XLEN-1:0] w_target;
  logic            w_misaligned;
  logic            w_is_ctrl;
  logic            w_taken;
  logic            w_accept;
  logic            w_event;

  branch_target_gen #(.XLEN(XLEN)) u_target (
    .i_pc           (ex_pc),
    .i_imm          (ex_imm),
    .i_rs1          (ex_rs1),
    .i_is_jalr      (ex_is_jalr),
    .o_target_c     (w_target),
    .o_misaligned_c (w_misaligned)
  );

  assign BrUn = ex_funct3[1];

  always_comb begin
    w_is_ctrl = ex_is_branch | ex_is_jal | ex_is_jalr;
    w_taken   = ex_is_jalr | ex_is_jal | (ex_is_branch & br_taken(ex_funct3, BrEq, BrLT));
    w_accept  = ex_valid & r_ex_ready & w_is_ctrl;
    w_event   = ex_valid & r_ex_ready & w_taken;
  end

  // Redirect/drain sequencer; exception pulse clears itself every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_ex_ready       <= 1'b1;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_exc_valid      <= 1'b0;
      r_exc_tval       <= '0;
      r_cnt            <= '0;
    end else begin
      r_exc_valid <= 1'b0;
      r_exc_tval  <= '0;
      case (r_state)
        IDLE: begin
          if (w_event) begin
            if (w_misaligned) begin
              r_exc_valid <= 1'b1;
              r_exc_tval  <= w_target;
            end else begin
              r_redirect_pc    <= w_target;
              r_redirect_valid <= 1'b1;
              r_flush          <= 1'b1;
              r_ex_ready       <= 1'b0;
              r_state          <= REDIRECT;
            end
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_cnt            <= CNT_W'(FLUSH_CYCLES - 1);
            r_state          <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_cnt == '0) begin
            r_flush    <= 1'b0;
            r_ex_ready <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state          <= IDLE;
          r_ex_ready       <= 1'b1;
          r_redirect_valid <= 1'b0;
          r_flush          <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] r_perf_ctrl;
  logic [31:0] r_perf_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_ctrl  <= '0;
      r_perf_taken <= '0;
    end else begin
      if (w_accept) r_perf_ctrl <= r_perf_ctrl + 32'd1;
      if (w_event && !w_misaligned) r_perf_taken <= r_perf_taken + 32'd1;
    end
  end

  assign perf_ctrl_cnt  = r_perf_ctrl;
  assign perf_taken_cnt = r_perf_taken;
`else
  logic w_unused;
  assign w_unused = w_accept;
`endif

  assign ex_ready       = r_ex_ready;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush_o        = r_flush;
  assign exc_valid      = r_exc_valid;
  assign exc_tval       = r_exc_tval;

endmodule
